// File: rtl/mem_stage_ctrl_pkg.sv
// Pipeline buffer types shared by the MEM stage: EX/MEM and MEM/WB layouts,
// the MEM-stage FSM state type and the load/store width codes.
package Pipe_Buf_Reg_PKG;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  reg_wb_src;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [6:0]  opcode;
    logic [31:0] pc_plus_4;
    logic [31:0] ALU_result;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic [31:0] tb_current_instr;
  } ex_mem_reg;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  reg_wb_src;
    logic [31:0] pc_plus_4;
    logic [31:0] ALU_result;
    logic [31:0] mem_read_data;
    logic [4:0]  rd;
    logic [31:0] tb_current_instr;
  } mem_wb_reg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic mem_wb_reg pack_wb(input logic        reg_write,
                                        input logic [1:0]  reg_wb_src,
                                        input logic [31:0] pc_plus_4,
                                        input logic [31:0] alu_result,
                                        input logic [31:0] read_data,
                                        input logic [4:0]  rd,
                                        input logic [31:0] instr);
    mem_wb_reg wb;
    wb.reg_write        = reg_write;
    wb.reg_wb_src       = reg_wb_src;
    wb.pc_plus_4        = pc_plus_4;
    wb.ALU_result       = alu_result;
    wb.mem_read_data    = read_data;
    wb.rd               = rd;
    wb.tb_current_instr = instr;
    return wb;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_align.sv
// Byte-lane steering for data memory: store enables/replicated data, load
// extraction with sign/zero extension, and legality of width vs. address.
module mem_align_unit
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [2:0]  i_funct3,
  input  logic        i_is_store,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_rd2,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_ext,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_lane)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Unsigned widths exist only for loads, so BU/HU on a store is illegal.
  always_comb begin
    o_be       = 4'b0000;
    o_wdata    = i_rd2;
    o_load_ext = i_rdata;
    o_misalign = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be       = 4'b0001 << i_lane;
        o_wdata    = {4{i_rd2[7:0]}};
        o_load_ext = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'b0, w_byte};
        o_misalign = i_is_store && (i_funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        o_be       = 4'b0011 << i_lane;
        o_wdata    = {2{i_rd2[15:0]}};
        o_load_ext = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'b0, w_half};
        o_misalign = i_lane[0] || (i_is_store && (i_funct3 == F3_HU));
      end
      F3_W: begin
        o_be       = 4'b1111;
        o_wdata    = i_rd2;
        o_load_ext = i_rdata;
        o_misalign = |i_lane;
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: turns the EX/MEM buffer into the MEM/WB buffer, running a
// req/gnt/rvalid data-memory handshake and stalling the front end meanwhile.
module mem_stage_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  ex_mem_reg   ex_mem_in,
  input  logic        ex_mem_valid,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output mem_wb_reg   mem_wb_out,
  output logic        mem_wb_valid,
  output logic        misalign_err,
  output logic        timeout_err
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t  r_state;
  ex_mem_reg   r_held;
  logic [7:0]  r_cnt;

  logic [2:0]  w_funct3;
  logic        w_is_store;
  logic [1:0]  w_lane;
  logic [31:0] w_rd2;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;
  logic        w_misalign;
  logic        w_mem_op;
  logic        w_illegal;
  logic        w_expire;
  logic        w_unused_opcode;

  // The aligner looks at the incoming op while idle (legality check) and at
  // the held op once an access is in flight.
  assign w_funct3   = (r_state == IDLE) ? ex_mem_in.funct3 : r_held.funct3;
  assign w_is_store = (r_state == IDLE) ? ex_mem_in.mem_write : r_held.mem_write;
  assign w_lane     = (r_state == IDLE) ? ex_mem_in.ALU_result[1:0] : r_held.ALU_result[1:0];
  assign w_rd2      = (r_state == IDLE) ? ex_mem_in.rd2 : r_held.rd2;

  mem_align_unit u_align (
    .i_funct3   (w_funct3),
    .i_is_store (w_is_store),
    .i_lane     (w_lane),
    .i_rd2      (w_rd2),
    .i_rdata    (dmem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_load_ext (w_load_ext),
    .o_misalign (w_misalign)
  );

  assign w_mem_op        = ex_mem_in.mem_read | ex_mem_in.mem_write;
  assign w_illegal       = (ex_mem_in.mem_read & ex_mem_in.mem_write) | w_misalign;
  assign w_expire        = (r_cnt == LP_LAST);
  assign w_unused_opcode = ^r_held.opcode;

  assign mem_stall  = (r_state != IDLE);
  assign dmem_req   = (r_state == REQ);
  assign dmem_we    = r_held.mem_write;
  assign dmem_addr  = {r_held.ALU_result[31:2], 2'b00};
  assign dmem_be    = w_be;
  assign dmem_wdata = w_wdata;

  // Single FSM: valid/error outputs default low and pulse only on an emit edge,
  // while mem_wb_out keeps its last value between emits. A completion in the
  // same cycle as timer expiry takes precedence over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_held       <= '0;
      r_cnt        <= '0;
      mem_wb_out   <= '0;
      mem_wb_valid <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mem_wb_valid <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ex_mem_valid) begin
            if (!w_mem_op) begin
              mem_wb_out   <= pack_wb(ex_mem_in.reg_write, ex_mem_in.reg_wb_src, ex_mem_in.pc_plus_4,
                                      ex_mem_in.ALU_result, 32'h0, ex_mem_in.rd, ex_mem_in.tb_current_instr);
              mem_wb_valid <= 1'b1;
            end else if (w_illegal) begin
              mem_wb_out   <= pack_wb(1'b0, ex_mem_in.reg_wb_src, ex_mem_in.pc_plus_4,
                                      ex_mem_in.ALU_result, 32'h0, ex_mem_in.rd, ex_mem_in.tb_current_instr);
              mem_wb_valid <= 1'b1;
              misalign_err <= 1'b1;
            end else begin
              r_held  <= ex_mem_in;
              r_cnt   <= '0;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (dmem_gnt && !r_held.mem_read) begin
            mem_wb_out   <= pack_wb(r_held.reg_write, r_held.reg_wb_src, r_held.pc_plus_4,
                                    r_held.ALU_result, 32'h0, r_held.rd, r_held.tb_current_instr);
            mem_wb_valid <= 1'b1;
            r_state      <= IDLE;
          end else if (w_expire) begin
            mem_wb_out   <= pack_wb(1'b0, r_held.reg_wb_src, r_held.pc_plus_4,
                                    r_held.ALU_result, 32'h0, r_held.rd, r_held.tb_current_instr);
            mem_wb_valid <= 1'b1;
            timeout_err  <= 1'b1;
            r_state      <= IDLE;
          end else if (dmem_gnt) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_cnt <= r_cnt + 8'd1;
          if (dmem_rvalid) begin
            mem_wb_out   <= pack_wb(r_held.reg_write, r_held.reg_wb_src, r_held.pc_plus_4,
                                    r_held.ALU_result, w_load_ext, r_held.rd, r_held.tb_current_instr);
            mem_wb_valid <= 1'b1;
            r_state      <= IDLE;
          end else if (w_expire) begin
            mem_wb_out   <= pack_wb(1'b0, r_held.reg_wb_src, r_held.pc_plus_4,
                                    r_held.ALU_result, 32'h0, r_held.rd, r_held.tb_current_instr);
            mem_wb_valid <= 1'b1;
            timeout_err  <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
